// File: rtl/rnn_pkg.sv
// rnn_pkg: shared states, register map and saturation helper for the RNN cell engine
package rnn_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_ROW_WB, S_COMMIT, S_DENSE, S_DENSE_WB, S_DONE
  } rnn_state_t;
  localparam logic [31:0] REG_CTRL = 32'd0;
  localparam logic [31:0] REG_X    = 32'd1;
  localparam logic [31:0] REG_WX   = 32'd2;
  localparam logic [31:0] REG_WH   = 32'd3;
  localparam logic [31:0] REG_B    = 32'd4;
  localparam logic [31:0] REG_D    = 32'd5;
  localparam logic [31:0] REG_DB   = 32'd6;
  localparam logic [31:0] REG_Y    = 32'd7;
  localparam logic [31:0] REG_H0   = 32'd8;
  localparam int CTRL_START   = 0;
  localparam int CTRL_CLEAR_H = 1;
  // Drops the fractional bits (toward -inf) and pins the result into [lo, hi].
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi,
                                                   input int frac);
    logic signed [63:0] s;
    s = acc >>> frac;
    return s < lo ? lo : s > hi ? hi : s;
  endfunction
endpackage

// File: rtl/rnn_cell_engine_if.sv
// rnn_cell_engine_if: word-addressed register bus between host and engine
interface rnn_cell_engine_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  modport master(output read, write, addr, data_in, input data_out);
  modport slave(input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/rnn_mac.sv
// rnn_mac: signed multiply-accumulate with bias load and clamp/saturate taps
module rnn_mac import rnn_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] clamp_q,
  output logic signed [DATA_W-1:0] sat_q
);
  logic signed [2*DATA_W-1:0] p;
  logic signed [ACC_W-1:0]    prod, acc;
  assign p    = a * b;
  assign prod = ACC_W'(p);
  // load restarts the sum at the scaled bias plus the first product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else acc <= load ? (ACC_W'(bias) <<< FRAC_W) + prod : en ? acc + prod : acc;
  end
  assign clamp_q = DATA_W'(sat_shift(64'(acc), -(64'sd1 <<< FRAC_W), 64'sd1 <<< FRAC_W, FRAC_W));
  assign sat_q   = DATA_W'(sat_shift(64'(acc), -(64'sd1 <<< (DATA_W-1)),
                                     (64'sd1 <<< (DATA_W-1)) - 64'sd1, FRAC_W));
endmodule

// File: rtl/tensor_1d.sv
// tensor_1d: vector register file with indexed write, bulk load and clear
module tensor_1d #(
  parameter int LEN    = 4,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         we,
  input  logic [7:0]                   idx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         ld,
  input  logic [LEN-1:0][DATA_W-1:0]   ld_data,
  output logic [LEN-1:0][DATA_W-1:0]   q
);
  // Indices that match no element are dropped, so nothing aliases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= ld_data;
    else for (int i = 0; i < LEN; i++) if (we && idx == 8'(i)) q[i] <= wdata;
  end
endmodule

// File: rtl/tensor_2d.sv
// tensor_2d: matrix register file with row/col indexed write
module tensor_2d #(
  parameter int ROWS   = 4,
  parameter int COLS   = 2,
  parameter int DATA_W = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   we,
  input  logic [7:0]                             row,
  input  logic [7:0]                             col,
  input  logic [DATA_W-1:0]                      wdata,
  output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  q
);
  // Only an exact in-range row/col match is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (we && row == 8'(r) && col == 8'(c)) q[r][c] <= wdata;
  end
endmodule

// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine: memory-mapped Elman RNN cell using one time-shared MAC
module rnn_cell_engine import rnn_pkg::*; #(
  parameter int IN_LEN  = 2,
  parameter int HID_LEN = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  rnn_cell_engine_if.slave  bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(IN_LEN+HID_LEN+2);
  localparam int NT    = IN_LEN + HID_LEN;
  localparam int CW    = $clog2(NT+1);
  localparam int RW    = $clog2(HID_LEN+1);
  rnn_state_t st, st_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic idle, wr, start, clr_h, mac_on, last_col;
  logic [7:0] r_in, i_in;
  logic [DATA_W-1:0] v_in;
  logic [IN_LEN-1:0][DATA_W-1:0] x_q;
  logic [HID_LEN-1:0][DATA_W-1:0] b_q, d_q, h_q, hn;
  logic [HID_LEN-1:0][IN_LEN-1:0][DATA_W-1:0] wx_q;
  logic [HID_LEN-1:0][HID_LEN-1:0][DATA_W-1:0] wh_q;
  logic signed [DATA_W-1:0] db, y, op_a, op_b, bias, clamp_q, sat_q;
  logic [31:0] rd;
  assign r_in     = bus.data_in[31:24];
  assign i_in     = bus.data_in[23:16];
  assign v_in     = bus.data_in[DATA_W-1:0];
  assign idle     = st == S_IDLE || st == S_DONE;
  assign wr       = bus.write && idle;
  assign start    = wr && bus.addr == REG_CTRL && bus.data_in[CTRL_START];
  assign clr_h    = wr && bus.addr == REG_CTRL && bus.data_in[CTRL_CLEAR_H];
  assign mac_on   = st == S_MAC || st == S_DENSE;
  assign last_col = st == S_MAC ? col == CW'(NT-1) : col == CW'(HID_LEN-1);
  tensor_1d #(.LEN(IN_LEN), .DATA_W(DATA_W)) u_x (.clk, .rst_n, .clr(1'b0),
    .we(wr && bus.addr == REG_X), .idx(i_in), .wdata(v_in), .ld(1'b0), .ld_data('0), .q(x_q));
  tensor_1d #(.LEN(HID_LEN), .DATA_W(DATA_W)) u_b (.clk, .rst_n, .clr(1'b0),
    .we(wr && bus.addr == REG_B), .idx(i_in), .wdata(v_in), .ld(1'b0), .ld_data('0), .q(b_q));
  tensor_1d #(.LEN(HID_LEN), .DATA_W(DATA_W)) u_d (.clk, .rst_n, .clr(1'b0),
    .we(wr && bus.addr == REG_D), .idx(i_in), .wdata(v_in), .ld(1'b0), .ld_data('0), .q(d_q));
  tensor_1d #(.LEN(HID_LEN), .DATA_W(DATA_W)) u_h (.clk, .rst_n, .clr(clr_h),
    .we(1'b0), .idx(8'd0), .wdata('0), .ld(st == S_COMMIT), .ld_data(hn), .q(h_q));
  tensor_2d #(.ROWS(HID_LEN), .COLS(IN_LEN), .DATA_W(DATA_W)) u_wx (.clk, .rst_n,
    .we(wr && bus.addr == REG_WX), .row(r_in), .col(i_in), .wdata(v_in), .q(wx_q));
  tensor_2d #(.ROWS(HID_LEN), .COLS(HID_LEN), .DATA_W(DATA_W)) u_wh (.clk, .rst_n,
    .we(wr && bus.addr == REG_WH), .row(r_in), .col(i_in), .wdata(v_in), .q(wh_q));
  rnn_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (.clk, .rst_n,
    .load(mac_on && col == '0), .en(mac_on), .bias, .a(op_a), .b(op_b), .clamp_q, .sat_q);
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else st <= st_nx;
  end
  // Sequencing: rows of MAC terms, then commit h, then the dense output.
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE, S_DONE: st_nx = start ? S_MAC : st;
      S_MAC:          st_nx = last_col ? S_ROW_WB : S_MAC;
      S_ROW_WB:       st_nx = row == RW'(HID_LEN-1) ? S_COMMIT : S_MAC;
      S_COMMIT:       st_nx = S_DENSE;
      S_DENSE:        st_nx = last_col ? S_DENSE_WB : S_DENSE;
      S_DENSE_WB:     st_nx = S_DONE;
      default:        st_nx = S_IDLE;
    endcase
  end
  // Term counter within a row/dense pass and the current hidden row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= mac_on && !last_col ? col + CW'(1) : '0;
      row <= st == S_ROW_WB ? row + RW'(1) : st == S_MAC ? row : '0;
    end
  end
  // Operand and bias select: Wx*x terms, then Wh*h terms, or d*h in the dense pass.
  always_comb begin
    op_a = '0;
    op_b = '0;
    bias = st == S_DENSE ? db : '0;
    for (int r = 0; r < HID_LEN; r++) begin
      if (st == S_MAC && row == RW'(r)) bias = b_q[r];
      for (int k = 0; k < IN_LEN; k++)
        if (st == S_MAC && row == RW'(r) && col == CW'(k)) {op_a, op_b} = {wx_q[r][k], x_q[k]};
      for (int k = 0; k < HID_LEN; k++)
        if (st == S_MAC && row == RW'(r) && col == CW'(IN_LEN+k)) {op_a, op_b} = {wh_q[r][k], h_q[k]};
    end
    for (int k = 0; k < HID_LEN; k++)
      if (st == S_DENSE && col == CW'(k)) {op_a, op_b} = {d_q[k], h_q[k]};
  end
  // Shadow h rows, output y and the dense bias db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hn <= '0;
      y  <= '0;
      db <= '0;
    end else begin
      for (int r = 0; r < HID_LEN; r++) if (st == S_ROW_WB && row == RW'(r)) hn[r] <= clamp_q;
      if (st == S_DENSE_WB) y <= sat_q;
      if (wr && bus.addr == REG_DB) db <= v_in;
    end
  end
  // Read decode of status, y and committed h.
  always_comb begin
    rd = '0;
    if (bus.addr == REG_CTRL) rd = {30'b0, st == S_DONE, !idle};
    if (bus.addr == REG_Y) rd = 32'(y);
    for (int k = 0; k < HID_LEN; k++) if (bus.addr == REG_H0 + 32'(k)) rd = 32'($signed(h_q[k]));
  end
  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.data_out <= '0;
    else if (bus.read) bus.data_out <= rd;
  end
endmodule

// File: tb/tb_rnn_cell_engine.sv
// tb_rnn_cell_engine: directed checks of the RNN cell engine register interface
module tb_rnn_cell_engine;
  import rnn_pkg::*;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0, cyc;
  logic [31:0] v;
  rnn_cell_engine_if bus();
  rnn_cell_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.write = 1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.write = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.read = 1; bus.addr = a;
    @(negedge clk);
    bus.read = 0;
    d = bus.data_out;
  endtask

  task automatic wr_t(input logic [31:0] a, input int r, input int i, input logic [15:0] val);
    bus_wr(a, {8'(r), 8'(i), val});
  endtask

  task automatic load_base;
    for (int j = 0; j < 4; j++) begin
      wr_t(REG_WX, j, 0, 16'h0080);
      wr_t(REG_WX, j, 1, 16'h0000);
      wr_t(REG_B, 0, j, 16'h0000);
      wr_t(REG_D, 0, j, 16'h0100);
      for (int k = 0; k < 4; k++) wr_t(REG_WH, j, k, 16'h0000);
    end
    wr_t(REG_X, 0, 0, 16'h0100);
    wr_t(REG_X, 0, 1, 16'h0000);
    wr_t(REG_DB, 0, 0, 16'h0000);
  endtask

  // Starts a step and polls STATUS every cycle; n is cycles until done was first read.
  task automatic run(input logic [31:0] ctrl, input bit inject, output int n);
    @(negedge clk);
    bus.write = 1; bus.addr = REG_CTRL; bus.data_in = ctrl;
    @(negedge clk);
    bus.write = 0; bus.read = 1; n = 0;
    do begin
      if (inject && n == 5) begin
        bus.write = 1; bus.addr = REG_B; bus.data_in = 32'h0003_0100;
      end else if (inject && n == 6) begin
        bus.write = 1; bus.addr = REG_CTRL; bus.data_in = 32'h1;
      end else begin
        bus.write = 0; bus.addr = REG_CTRL;
      end
      @(negedge clk);
      n++;
    end while (!bus.data_out[1] && n < 200);
    bus.read = 0; bus.write = 0;
  endtask

  task automatic check_h(input string tag, input logic [31:0] exp);
    for (int k = 0; k < 4; k++) begin
      bus_rd(REG_H0 + 32'(k), v);
      check($sformatf("%s h%0d", tag, k), v, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic [31:0] h_exp, input logic [31:0] y_exp);
    check({tag, " latency"}, 32'(cyc - 1), 32'd34);
    check_h(tag, h_exp);
    bus_rd(REG_Y, v);
    check({tag, " y"}, v, y_exp);
  endtask

  initial begin
    bus.read = 0; bus.write = 0; bus.addr = 0; bus.data_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    bus_rd(REG_CTRL, v); check("reset status", v, 32'h0);
    bus_rd(REG_Y, v); check("reset y", v, 32'h0);
    check_h("reset", 32'h0);
    load_base;
    run(32'h1, 0, cyc);
    check_step("basic", 32'h0080, 32'h0200);
    bus_rd(REG_CTRL, v); check("basic status", v, 32'h2);
    for (int j = 0; j < 4; j++) wr_t(REG_WH, j, j, 16'h0080);
    wr_t(REG_X, 0, 0, 16'h0000);
    run(32'h1, 0, cyc);
    check_step("recur1", 32'h0040, 32'h0100);
    run(32'h1, 0, cyc);
    check_step("recur2", 32'h0020, 32'h0080);
    wr_t(REG_WX, 0, 0, 16'h7FFF);
    wr_t(REG_X, 0, 0, 16'h7FFF);
    run(32'h1, 0, cyc);
    bus_rd(REG_H0, v); check("clamp hi", v, 32'h0000_0100);
    wr_t(REG_X, 0, 0, 16'h8000);
    run(32'h1, 0, cyc);
    bus_rd(REG_H0, v); check("clamp lo", v, 32'hFFFF_FF00);
    bus_rd(REG_Y, v); check("clamp y", v, 32'hFFFF_FC00);
    bus_wr(REG_CTRL, 32'h2);
    bus_rd(REG_H0 + 32'd2, v); check("clear_h h2", v, 32'h0);
    bus_rd(REG_Y, v); check("clear_h y kept", v, 32'hFFFF_FC00);
    load_base;
    wr_t(REG_B, 0, 9, 16'h0100);
    wr_t(REG_WX, 4, 0, 16'h7FFF);
    run(32'h3, 1, cyc);
    check_step("protect", 32'h0080, 32'h0200);
    bus_wr(REG_CTRL, 32'h1);
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk) rst_n = 1;
    bus_rd(REG_CTRL, v); check("abort status", v, 32'h0);
    bus_rd(REG_Y, v); check("abort y", v, 32'h0);
    check_h("abort", 32'h0);
    load_base;
    run(32'h1, 0, cyc);
    check_step("after reset", 32'h0080, 32'h0200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
